// File: rtl/row_col_cod_nxn.sv
// Slew-limited row/column selector for a SIZE x SIZE DCO unit-capacitor array.
// The code moves toward the clamped tuning word in steps of at most STEP_MAX units and is encoded into row/column enables.
module row_col_cod_nxn #(
    parameter int unsigned SIZE     = 8,
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned MAX      = SIZE * SIZE,
    parameter int unsigned STEP_MAX = SIZE,
    parameter int unsigned RST_CODE = SIZE * SIZE / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] code,
    output logic [SIZE-1:0]  r_all,
    output logic [SIZE-1:0]  row,
    output logic [SIZE-1:0]  col,
    output logic             settled,
    output logic             ovr
);

    localparam int unsigned EW = WIDTH + 1;

    logic [WIDTH-1:0] r_code;
    logic [SIZE-1:0]  r_r_all;
    logic [SIZE-1:0]  r_row;
    logic [SIZE-1:0]  r_col;
    logic             r_settled;
    logic             r_ovr;

    logic [EW-1:0]    w_word_x;
    logic [EW-1:0]    w_tgt_x;
    logic [EW-1:0]    w_code_x;
    logic [EW-1:0]    w_diff;
    logic [EW-1:0]    w_code_nxt_x;
    logic [WIDTH-1:0] w_code_nxt;
    logic             w_ovr;
    logic             w_settled;
    logic [SIZE-1:0]  w_r_all;
    logic [SIZE-1:0]  w_row;
    logic [SIZE-1:0]  w_col;

    // Row index and fill count via a comparator chain: {ri, nc}, where nc is 1..SIZE for nonzero codes.
    function automatic logic [2*EW-1:0] f_split(input logic [WIDTH-1:0] c);
        logic [EW-1:0] ri;
        logic [EW-1:0] nc;
        ri = '0;
        nc = {1'b0, c};
        for (int unsigned i = 1; i < SIZE; i++) begin
            if ({1'b0, c} > EW'(i * SIZE)) begin
                ri = EW'(i);
                nc = {1'b0, c} - EW'(i * SIZE);
            end
        end
        return {ri, nc};
    endfunction

    function automatic logic [SIZE-1:0] f_r_all(input logic [WIDTH-1:0] c);
        logic [2*EW-1:0] s;
        logic [SIZE-1:0] v;
        s = f_split(c);
        for (int unsigned i = 0; i < SIZE; i++) begin
            v[i] = !(EW'(i) < s[2*EW-1:EW]);
        end
        return v;
    endfunction

    function automatic logic [SIZE-1:0] f_row(input logic [WIDTH-1:0] c);
        logic [2*EW-1:0] s;
        logic [SIZE-1:0] v;
        s = f_split(c);
        for (int unsigned i = 0; i < SIZE; i++) begin
            v[i] = (EW'(i) == s[2*EW-1:EW]);
        end
        return v;
    endfunction

    // Even rows fill from column 0 upward, odd rows from the top column down (serpentine).
    function automatic logic [SIZE-1:0] f_col(input logic [WIDTH-1:0] c);
        logic [2*EW-1:0] s;
        logic [SIZE-1:0] v;
        s = f_split(c);
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (s[EW])
                v[i] = (EW'(i) + s[EW-1:0] >= EW'(SIZE));
            else
                v[i] = (EW'(i) < s[EW-1:0]);
        end
        return v;
    endfunction

    // Clamp, slew-limit and encode the next code; all arithmetic one bit wider than the word.
    always_comb begin
        w_word_x     = {1'b0, word};
        w_ovr        = (w_word_x > EW'(MAX));
        w_tgt_x      = w_ovr ? EW'(MAX) : w_word_x;
        w_code_x     = {1'b0, r_code};
        w_diff       = (w_tgt_x >= w_code_x) ? (w_tgt_x - w_code_x) : (w_code_x - w_tgt_x);
        w_code_nxt_x = w_tgt_x;
        if (!load && (w_diff > EW'(STEP_MAX))) begin
            if (w_tgt_x > w_code_x)
                w_code_nxt_x = w_code_x + EW'(STEP_MAX);
            else
                w_code_nxt_x = w_code_x - EW'(STEP_MAX);
        end
        w_settled  = (w_code_nxt_x == w_tgt_x);
        w_code_nxt = w_code_nxt_x[WIDTH-1:0];
        w_r_all    = f_r_all(w_code_nxt);
        w_row      = f_row(w_code_nxt);
        w_col      = f_col(w_code_nxt);
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_code    <= WIDTH'(RST_CODE);
            r_r_all   <= f_r_all(WIDTH'(RST_CODE));
            r_row     <= f_row(WIDTH'(RST_CODE));
            r_col     <= f_col(WIDTH'(RST_CODE));
            r_settled <= 1'b1;
            r_ovr     <= 1'b0;
        end else if (en) begin
            r_code    <= w_code_nxt;
            r_r_all   <= w_r_all;
            r_row     <= w_row;
            r_col     <= w_col;
            r_settled <= w_settled;
            r_ovr     <= w_ovr;
        end
    end

    assign code    = r_code;
    assign r_all   = r_r_all;
    assign row     = r_row;
    assign col     = r_col;
    assign settled = r_settled;
    assign ovr     = r_ovr;

endmodule

// File: doc/row_col_cod_nxn.md
Name: row_col_cod_nxn

Overview:
- Parametrised successor to the fixed 5x5 row/column selector for the DCO unit-capacitor array.
- Converts a binary tuning word into three codes for an SIZE x SIZE array: active-low full-row enables (r_all), one-hot partial-row select (row) and serpentine thermometer column enables (col).
- New behaviour: the internal code is slew-limited, so it moves toward the requested word by at most STEP_MAX units per update, which limits DCO frequency jumps.
- Also adds an immediate-load mode, clamping with an overflow flag, and a settled indicator.
- Sits between the ADPLL loop filter / tuning-word path and the DCO bank.

Parameters:
- SIZE, 8, rows = columns of the array; valid range 2..16.
- WIDTH, 7, width of word and code; must satisfy 2^WIDTH > SIZE*SIZE.
- MAX, SIZE*SIZE, largest legal code; higher words are clamped to MAX.
- STEP_MAX, SIZE, largest change of code per enabled update; must be >= 1.
- RST_CODE, SIZE*SIZE/2, value of code after reset; must be <= MAX.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  update enable, sampled on the falling edge of clk.
- load  in  1  1 = jump directly to the target; 0 = slew-limited step.
- word  in  WIDTH  requested tuning word, unsigned.
- code  out  WIDTH  registered current code, i.e. number of active units.
- r_all  out  SIZE  full-row enables, active-low; bit i = 0 means row i is fully on.
- row  out  SIZE  one-hot select of the partially filled row.
- col  out  SIZE  column enables applied to the selected row.
- settled  out  1  registered; 1 when code equals the clamped target.
- ovr  out  1  registered; 1 when the last sampled word was > MAX.

Behaviour:
- Reset: async on posedge rst; acts immediately, including mid-ramp.
  - code = RST_CODE; r_all, row, col = encoding of RST_CODE; settled = 1; ovr = 0.
- Clamped target: tgt = min(word, MAX).
- Update on each falling edge with en = 1 and rst = 0:
  - load = 1: code <= tgt.
  - load = 0 and |tgt - code| <= STEP_MAX: code <= tgt.
  - load = 0 otherwise: code <= code + STEP_MAX (tgt > code) or code - STEP_MAX (tgt < code).
  - settled <= (new code == tgt).
  - ovr <= (word > MAX).
- en = 0: all outputs hold; word and load are ignored.
- Arithmetic: difference and sum are computed in WIDTH+1 bits so there is no wrap-around. code never goes outside 0..MAX.
- Encoding is a pure function of the new code value, registered on the same edge as code, so outputs are always mutually consistent and the latency is 1 edge.
  - code = 0: ri = 0, nc = 0.
  - code > 0: ri = (code-1)/SIZE, nc = code - ri*SIZE, so nc is in 1..SIZE.
  - r_all[i] = 0 for i < ri, else 1.
  - row[i] = 1 only for i == ri.
  - ri even: col[i] = 1 for i < nc, else 0.
  - ri odd: col[i] = 1 for i >= SIZE-nc, else 0 (serpentine fill).
  - Invariant: ri*SIZE + popcount(col) == code.
- The divide is implemented as a comparator chain or loop over SIZE. No true divider is required; the logic must meet timing within a half clock period.
- Both edge cases are legal and must encode exactly as above:
  - code == MAX: ri = SIZE-1, nc = SIZE.
  - code == exact row multiple: nc = SIZE, row not yet advanced.

Test Plan (SIZE=8, WIDTH=7, STEP_MAX=8, RST_CODE=32):
- Assert rst asynchronously mid-cycle → immediately code=32, r_all=8'hF8, row=8'h08, col=8'hFF, settled=1, ovr=0.
- en=1, load=1, word=0, one negedge → code=0, r_all=8'hFF, row=8'h01, col=8'h00, settled=1. Then word=13 with load=1 → code=13, r_all=8'hFE, row=8'h02, col=8'hF8.
- From code=0: load=0, word=20 held → code goes 8, 16, 20 on three edges; settled goes 0, 0, 1.
  - At 8: r_all=FF, row=01, col=FF.
  - At 16: r_all=FE, row=02, col=FF.
  - At 20: r_all=FC, row=04, col=0F.
- load=1, word=100 → code=64, ovr=1, r_all=8'h80, row=8'h80, col=8'hFF, settled=1. Then word=64 → ovr=0, code stays 64.
- Mid-ramp from 0 toward 40: drop en for 3 edges → code and all outputs frozen. Then assert rst → code=32 immediately; after release, stepping resumes toward 40 from 32 (next code=40).
- Random regression: 10k random word/load/en values → check the invariant ri*SIZE + popcount(col) == code, one-hot row, r_all thermometer, and |Δcode| <= 8 whenever load=0.
